toeplitz_colgen_par: RTL and testbench
======================================

Name: toeplitz_colgen_par

Overview:
Parallel, streaming successor to the single-column Toeplitz generator. It accepts a seed (first row and first column) through a valid/ready handshake and emits P consecutive matrix columns per beat over a backpressured valid/ready output. It supports one-shot or continuous (auto-reload) operation and an abort. It feeds the Toeplitz extractor datapath. Optionally it accumulates the matrix-vector product (hash) in place.

Parameters:
N, 256, row length = number of columns per matrix; must be a multiple of P.
L, 128, column height (bits per column).
P, 4, columns emitted per beat; must satisfy 1 <= P <= N.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
seed_valid  in  1  seed offered
seed_ready  out  1  seed accepted when seed_valid&&seed_ready
row0  in  N  first row seed
col0  in  L  first column seed
cfg_repeat  in  1  sampled at seed accept; 1 = auto-reload stored seed after last beat
abort  in  1  return to IDLE next cycle
out_valid  out  1  beat valid
out_ready  in  1  sink accepts beat
out_cols  out  P*L  out_cols[j*L +: L] = column k+j
out_idx  out  $clog2(N)  index k of first column in beat
out_last  out  1  beat contains column N-1
busy  out  1  state != IDLE
data_in  in  P  input bits for hash, sampled on out handshake
hash_out  out  L  accumulated hash
hash_valid  out  1  one-cycle pulse, hash_out final

Behaviour:
- Column recurrence, k = 0..N-1:
  - col_0 = col0, r_0 = row0.
  - col_{k+1} = {r_k[N-1], col_k[L-1:1]}.
  - r_{k+1} = r_k << 1.
- Internal registers: current column C, current row R, stored seed copy, repeat flag, column index.
- Beat columns C..C+P-1 are computed combinationally by P unrolled recurrence steps from C and R. Outputs come from registers and internal combinational logic only; there is no input-to-output combinational path.
- States: IDLE, RUN.
- IDLE:
  - seed_ready=1, out_valid=0.
  - On seed handshake: load C=col0 and R=row0, store the seed copy, latch cfg_repeat, set idx=0, go to RUN.
  - First beat has out_valid=1 on the next cycle (latency 1).
- RUN:
  - seed_ready=0, out_valid=1.
  - out_cols, out_idx and out_last stay stable until the handshake.
  - On handshake: C <= col_{k+P}, R <= R << P, idx += P.
- out_last = (idx == N-P).
- Handshake on the last beat:
  - Repeat flag set: reload C and R from the stored seed, set idx=0, stay in RUN. out_valid stays high with no bubble.
  - Repeat flag clear: go to IDLE.
- abort:
  - Has priority over handshakes.
  - Next cycle: IDLE, out_valid=0, idx=0.
  - A beat whose handshake coincides with abort counts as consumed; no further beats follow.
- A seed presented while in RUN is not accepted (seed_ready=0). It waits.
- Reset values: state IDLE, seed_ready 1 after reset deasserts (0 during reset), out_valid 0, out_idx 0, out_last 0, busy 0, out_cols 0, hash_out 0, hash_valid 0.
- Reset mid-run discards everything, including the stored seed.

Optional Feature:
Macro TOEPLITZ_HASH_EN.
- Defined:
  - On each out handshake, acc ^= XOR over j of (data_in[j] ? column k+j : 0).
  - acc clears on seed accept and on repeat reload.
  - The handshake on the last beat registers the final value into hash_out and pulses hash_valid for one cycle on the next cycle.
  - abort clears acc without pulsing hash_valid.
- Not defined:
  - hash_out and hash_valid are tied to 0.
  - data_in is ignored.
  - No accumulator logic is generated.

Test Plan:
- N=8, L=4, P=2, row0=8'h81, col0=4'h5, cfg_repeat=0, out_ready=1 -> beat0 out_cols=8'hA5 idx0; beat1 8'h25 idx2; 4 beats total; out_last only on idx6; then IDLE, busy=0.
- Same seed, out_ready toggling 1/0 randomly -> identical beat sequence; outputs stable while out_ready=0; no beat dropped or duplicated.
- cfg_repeat=1, out_ready=1 for 10 beats -> beats 0-3 repeat, idx sequence 0,2,4,6,0,2,...; out_valid continuously high.
- abort asserted during beat idx2 with out_ready=1 -> next cycle out_valid=0, seed_ready=1. A new seed 8'hFF/4'h0 then yields beat0 {4'h8,4'h0}=8'h80.
- TOEPLITZ_HASH_EN defined, seed 8'h81/4'h5, data_in=2'b01 every beat -> hash_out = col0^col2^col4^col6 (golden-model computed), hash_valid pulses exactly once. A second run after reset mid-run pulses no stale hash.
- Reset asserted mid-RUN for one cycle -> all outputs at reset values next cycle; a fresh seed then produces beat0 at latency 1.

Source files
------------

// File: rtl/toeplitz_colgen_par.sv
// Streaming Toeplitz column generator, P columns per beat; TOEPLITZ_HASH_EN adds an in-place hash accumulator.
// Latency 1 from seed accept to first beat; a beat holds stable while out_ready is low.
module toeplitz_colgen_par #(
    parameter int N = 256,
    parameter int L = 128,
    parameter int P = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic [N-1:0]         row0,
    input  logic [L-1:0]         col0,
    input  logic                 cfg_repeat,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P*L-1:0]       out_cols,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 busy,
    input  logic [P-1:0]         data_in,
    output logic [L-1:0]         hash_out,
    output logic                 hash_valid
);
    localparam int IW = $clog2(N);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [L-1:0]   r_col;
    logic [N-1:0]   r_row;
    logic [L-1:0]   r_seed_col;
    logic [N-1:0]   r_seed_row;
    logic           r_repeat;
    logic [IW-1:0]  r_idx;

    logic [P*L-1:0] w_cols;
    logic [L-1:0]   w_col_nxt;
    logic [N-1:0]   w_row_nxt;
    logic           w_seed_hs;
    logic           w_out_hs;
    logic           w_last;
    logic           w_abort_run;
`ifdef TOEPLITZ_HASH_EN
    logic [L-1:0]   w_contrib;
`endif

    // P unrolled recurrence steps; the final step yields the state for the next beat.
    always_comb begin
        logic [L-1:0] c;
        logic [N-1:0] r;
        logic [L:0]   e;
        c      = r_col;
        r      = r_row;
        e      = '0;
        w_cols = '0;
`ifdef TOEPLITZ_HASH_EN
        w_contrib = '0;
`endif
        for (int j = 0; j < P; j++) begin
            w_cols[j*L +: L] = c;
`ifdef TOEPLITZ_HASH_EN
            if (data_in[j]) w_contrib = w_contrib ^ c;
`endif
            e = {r[N-1], c};
            c = e[L:1];
            r = r << 1;
        end
        w_col_nxt = c;
        w_row_nxt = r;
    end

    assign w_seed_hs   = seed_valid && seed_ready;
    assign w_out_hs    = out_valid && out_ready;
    assign w_abort_run = abort && (r_state == S_RUN);
    assign w_last      = (r_idx == IW'(N - P));

    assign out_cols = w_cols;
    assign out_idx  = r_idx;
    assign out_last = (r_state == S_RUN) && w_last;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_seed_hs) w_state_nxt = S_RUN;
            S_RUN: begin
                if (abort)                              w_state_nxt = S_IDLE;
                else if (w_out_hs && w_last && !r_repeat) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        seed_ready = (r_state == S_IDLE) && !reset;
        out_valid  = (r_state == S_RUN);
        busy       = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_seed_col <= '0;
            r_seed_row <= '0;
            r_repeat   <= 1'b0;
            r_idx      <= '0;
        end else if (w_abort_run) begin
            r_idx <= '0;
        end else if (w_seed_hs) begin
            r_col      <= col0;
            r_row      <= row0;
            r_seed_col <= col0;
            r_seed_row <= row0;
            r_repeat   <= cfg_repeat;
            r_idx      <= '0;
        end else if (w_out_hs) begin
            if (w_last && r_repeat) begin
                r_col <= r_seed_col;
                r_row <= r_seed_row;
                r_idx <= '0;
            end else begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                r_idx <= w_last ? '0 : r_idx + IW'(P);
            end
        end
    end

`ifdef TOEPLITZ_HASH_EN
    logic [L-1:0] r_acc;
    logic [L-1:0] r_hash;
    logic         r_hash_vld;

    // Abort wins over a coincident last-beat handshake, so no pulse in that case.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_hash     <= '0;
            r_hash_vld <= 1'b0;
        end else begin
            r_hash_vld <= 1'b0;
            if (w_abort_run || w_seed_hs) begin
                r_acc <= '0;
            end else if (w_out_hs) begin
                if (w_last) begin
                    r_acc      <= '0;
                    r_hash     <= r_acc ^ w_contrib;
                    r_hash_vld <= 1'b1;
                end else begin
                    r_acc <= r_acc ^ w_contrib;
                end
            end
        end
    end

    assign hash_out   = r_hash;
    assign hash_valid = r_hash_vld;
`else
    logic w_unused_data;
    assign w_unused_data = ^data_in;
    assign hash_out      = '0;
    assign hash_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_toeplitz_colgen_par.sv
// Directed bench for toeplitz_colgen_par (N=8, L=4, P=2) with a beat scoreboard and hash model.
module tb_toeplitz_colgen_par;
    localparam int N  = 8;
    localparam int L  = 4;
    localparam int P  = 2;
    localparam int IW = 3;
`ifdef TOEPLITZ_HASH_EN
    localparam bit HASH = 1'b1;
`else
    localparam bit HASH = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           seed_valid;
    logic           seed_ready;
    logic [N-1:0]   row0;
    logic [L-1:0]   col0;
    logic           cfg_repeat;
    logic           abort;
    logic           out_valid;
    logic           out_ready;
    logic [P*L-1:0] out_cols;
    logic [IW-1:0]  out_idx;
    logic           out_last;
    logic           busy;
    logic [P-1:0]   data_in;
    logic [L-1:0]   hash_out;
    logic           hash_valid;

    toeplitz_colgen_par #(.N(N), .L(L), .P(P)) dut (
        .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed_ready(seed_ready),
        .row0(row0), .col0(col0), .cfg_repeat(cfg_repeat), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_cols(out_cols),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .data_in(data_in),
        .hash_out(hash_out), .hash_valid(hash_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [P*L-1:0] cols;
        logic [IW-1:0]  idx;
        logic           last;
    } beat_t;

    beat_t        q[$];
    int           checks = 0;
    int           errors = 0;
    int           hv_count = 0;
    logic [L-1:0] acc_m;
    logic [L-1:0] hash_exp;
    bit           hash_due;

    always @(posedge clk) if (hash_valid === 1'b1) hv_count++;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L-1:0] col_k(input logic [N-1:0] row, input logic [L-1:0] col, input int k);
        logic [L-1:0] c = col;
        logic [N-1:0] r = row;
        for (int i = 0; i < k; i++) begin
            c = {r[N-1], c[L-1:1]};
            r = r << 1;
        end
        return c;
    endfunction

    function automatic beat_t mk_beat(input logic [N-1:0] row, input logic [L-1:0] col, input int k);
        beat_t b;
        b.cols = '0;
        for (int j = 0; j < P; j++) b.cols[j*L +: L] = col_k(row, col, k + j);
        b.idx  = IW'(k);
        b.last = (k == N - P);
        return b;
    endfunction

    task automatic push_beats(input logic [N-1:0] row, input logic [L-1:0] col, input int n);
        for (int b = 0; b < n; b++) q.push_back(mk_beat(row, col, (b * P) % N));
    endtask

    task automatic hash_tick();
        if (hash_due) begin
            chk("hash_valid_pulse", hash_valid, HASH);
            chk("hash_out_final", hash_out, HASH ? hash_exp : '0);
            hash_due = 1'b0;
        end
    endtask

    task automatic send_seed(input logic [N-1:0] row, input logic [L-1:0] col, input logic rep);
        int t = 0;
        @(negedge clk);
        seed_valid = 1'b1;
        row0       = row;
        col0       = col;
        cfg_repeat = rep;
        while (seed_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("seed_accept_wait", t < 50, 1);
        @(negedge clk);
        seed_valid = 1'b0;
        acc_m      = '0;
        chk("first_beat_latency1", out_valid, 1);
        chk("busy_in_run", busy, 1);
        chk("seed_ready_in_run", seed_ready, 0);
    endtask

    task automatic collect(input int n, input bit rnd, output int gaps);
        int    got = 0;
        int    cyc = 0;
        beat_t h;
        gaps = 0;
        while (got < n && cyc < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) data_in = P'($urandom);
            if (out_valid !== 1'b1) begin
                gaps++;
            end else if (q.size() == 0) begin
                chk("spurious_beat", out_valid, 0);
            end else begin
                h = q[0];
                chk("beat_cols", out_cols, h.cols);
                chk("beat_idx", out_idx, h.idx);
                chk("beat_last", out_last, h.last);
                if (out_ready) begin
                    void'(q.pop_front());
                    got++;
                    for (int j = 0; j < P; j++) if (data_in[j]) acc_m = acc_m ^ h.cols[j*L +: L];
                    if (h.last) begin
                        hash_exp = acc_m;
                        hash_due = 1'b1;
                        acc_m    = '0;
                    end
                end
            end
            @(negedge clk);
            cyc++;
            hash_tick();
        end
        chk("beats_delivered", got, n);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_seed_ready"}, seed_ready, 1);
    endtask

    initial begin
        int g;
        int hv_base;
        logic [L-1:0] gold;
        reset = 1'b1; seed_valid = 1'b0; row0 = '0; col0 = '0; cfg_repeat = 1'b0;
        abort = 1'b0; out_ready = 1'b0; data_in = 2'b01;
        acc_m = '0; hash_exp = '0; hash_due = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seed_ready", seed_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_cols", out_cols, 0);
        chk("rst_hash_out", hash_out, 0);
        chk("rst_hash_valid", hash_valid, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_seed_ready", seed_ready, 1);

        // One-shot run, sink always ready.
        hv_base = hv_count;
        push_beats(8'h81, 4'h5, 4);
        send_seed(8'h81, 4'h5, 1'b0);
        chk("oneshot_beat0_const", out_cols, 8'hA5);
        collect(4, 1'b0, g);
        gold = col_k(8'h81, 4'h5, 0) ^ col_k(8'h81, 4'h5, 2) ^ col_k(8'h81, 4'h5, 4) ^ col_k(8'h81, 4'h5, 6);
        chk("oneshot_hash_golden", hash_out, HASH ? gold : '0);
        @(negedge clk);
        chk_idle("oneshot_end");
        chk("oneshot_hash_pulses", hv_count - hv_base, HASH ? 1 : 0);
        chk("oneshot_hash_valid_low", hash_valid, 0);

        // Same seed with random backpressure and random hash input.
        hv_base = hv_count;
        push_beats(8'h81, 4'h5, 4);
        send_seed(8'h81, 4'h5, 1'b0);
        collect(4, 1'b1, g);
        @(negedge clk);
        chk_idle("bp_end");
        chk("bp_hash_pulses", hv_count - hv_base, HASH ? 1 : 0);

        // Auto-reload: 10 beats with no bubble across the wrap.
        data_in = 2'b01;
        hv_base = hv_count;
        push_beats(8'h81, 4'h5, 10);
        send_seed(8'h81, 4'h5, 1'b1);
        collect(10, 1'b0, g);
        chk("repeat_no_gaps", g, 0);
        chk("repeat_still_valid", out_valid, 1);
        chk("repeat_idx_after10", out_idx, 4);
        out_ready = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        q.delete();
        chk_idle("repeat_abort");
        chk("repeat_abort_idx", out_idx, 0);
        chk("repeat_hash_pulses", hv_count - hv_base, HASH ? 2 : 0);

        // Abort coinciding with the handshake of beat idx2.
        hv_base = hv_count;
        push_beats(8'h81, 4'h5, 4);
        send_seed(8'h81, 4'h5, 1'b0);
        collect(1, 1'b0, g);
        chk("abort_at_idx2", out_idx, 2);
        chk("abort_beat1_const", out_cols, 8'h25);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        q.delete();
        chk_idle("abort_next");
        chk("abort_idx_cleared", out_idx, 0);
        @(negedge clk);
        chk("abort_no_more_beats", out_valid, 0);
        chk("abort_no_hash_pulse", hv_count - hv_base, 0);
        push_beats(8'hFF, 4'h0, 4);
        send_seed(8'hFF, 4'h0, 1'b0);
        chk("newseed_beat0_const", out_cols, 8'h80);
        collect(4, 1'b0, g);

        // Reset in the middle of a run.
        push_beats(8'h81, 4'h5, 4);
        send_seed(8'h81, 4'h5, 1'b0);
        collect(2, 1'b0, g);
        hv_base   = hv_count;
        reset     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_seed_ready", seed_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_idx", out_idx, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_cols", out_cols, 0);
        chk("midrst_hash_out", hash_out, 0);
        chk("midrst_hash_valid", hash_valid, 0);
        reset = 1'b0;
        q.delete();
        acc_m    = '0;
        hash_due = 1'b0;
        #1;
        chk("midrst_seed_ready_after", seed_ready, 1);
        @(negedge clk);
        chk("midrst_no_stale_pulse", hv_count - hv_base, 0);
        data_in = 2'b01;
        push_beats(8'h81, 4'h5, 4);
        send_seed(8'h81, 4'h5, 1'b0);
        chk("midrst_fresh_beat0", out_cols, 8'hA5);
        collect(4, 1'b0, g);
        chk("midrst_rerun_hash", hash_out, HASH ? gold : '0);
        @(negedge clk);
        chk_idle("midrst_rerun_end");
        chk("midrst_rerun_pulses", hv_count - hv_base, HASH ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
